// File: rtl/phy_rx_param_if.sv
// Serial-in / lane-parallel-out bundle for the comma-aligned receiver.
// The master side feeds serial bits; the slave side (the receiver) drives the lane outputs.
interface phy_rx_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LANES  = 4
);
    logic                            serial_in;
    logic [NUM_LANES*DATA_WIDTH-1:0] data_out;
    logic [NUM_LANES-1:0]            valid_out;
    logic                            out_strobe;
    logic                            idle_out;
    logic                            sync_ok;

    modport master (
        output serial_in,
        input  data_out, valid_out, out_strobe, idle_out, sync_ok
    );

    modport slave (
        input  serial_in,
        output data_out, valid_out, out_strobe, idle_out, sync_ok
    );
endinterface

// File: rtl/phy_rx_param.sv
// Serial receiver: comma-based symbol alignment, sync/loss tracking, and
// deserialisation of aligned symbols into NUM_LANES parallel output lanes.
module phy_rx_param #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    NUM_LANES  = 4,
    parameter logic [DATA_WIDTH-1:0] COM        = DATA_WIDTH'(8'hBC),
    parameter int                    SYNC_COUNT = 4,
    parameter int                    LOS_COUNT  = 4
) (
    input  logic         clk_32f,
    input  logic         rst,
    phy_rx_param_if.slave bus
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CW = $clog2(SYNC_COUNT + 1);
    localparam int SW = $clog2(LOS_COUNT + 1);

    typedef enum logic [0:0] {SEARCH, SYNCED} state_t;

    state_t                          state, state_next;
    logic [DATA_WIDTH-2:0]           hist;
    logic [DATA_WIDTH-1:0]           sr_next;
    logic                            match, boundary;
    logic [BW-1:0]                   bit_cnt;
    logic [CW-1:0]                   com_cnt, com_upd;
    logic [SW-1:0]                   los_cnt, los_inc;
    logic                            acquire, los_hit;
    logic [LW-1:0]                   lane;
    logic                            last_lane;
    logic [DATA_WIDTH-1:0]           word_buf [NUM_LANES];
    logic [NUM_LANES-1:0]            vbuf;
    logic [NUM_LANES*DATA_WIDTH-1:0] round_data, data_q;
    logic [NUM_LANES-1:0]            round_valid, valid_q;
    logic                            strobe_q, idle_q;

    // Only the low DATA_WIDTH-1 history bits are kept; the oldest bit falls off on every shift.
    assign sr_next   = {hist, bus.serial_in};
    assign match     = (sr_next == COM);
    assign boundary  = (bit_cnt == BW'(DATA_WIDTH - 1));
    assign last_lane = (lane == LW'(NUM_LANES - 1));

    // A comma only extends the run when it lands exactly one symbol after the previous one.
    assign com_upd = (boundary && com_cnt != '0)
                   ? ((com_cnt == CW'(SYNC_COUNT)) ? com_cnt : com_cnt + CW'(1))
                   : CW'(1);
    assign los_inc = (los_cnt == SW'(LOS_COUNT)) ? los_cnt : los_cnt + SW'(1);
    assign acquire = match && (com_upd == CW'(SYNC_COUNT));
    assign los_hit = match && !boundary && (los_inc == SW'(LOS_COUNT));

    always_comb begin
        round_data  = '0;
        round_valid = '0;
        for (int k = 0; k < NUM_LANES - 1; k++) begin
            round_data[k*DATA_WIDTH +: DATA_WIDTH] = word_buf[k];
            round_valid[k]                         = vbuf[k];
        end
        round_data[(NUM_LANES-1)*DATA_WIDTH +: DATA_WIDTH] = sr_next;
        round_valid[NUM_LANES-1]                           = !match;
    end

    always_ff @(posedge clk_32f) begin
        if (rst) state <= SEARCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            SEARCH:  if (acquire) state_next = SYNCED;
            SYNCED:  if (los_hit) state_next = SEARCH;
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (rst) begin
            hist     <= '0;
            bit_cnt  <= '0;
            com_cnt  <= '0;
            los_cnt  <= '0;
            lane     <= '0;
            vbuf     <= '0;
            data_q   <= '0;
            valid_q  <= '0;
            strobe_q <= 1'b0;
            idle_q   <= 1'b1;
            for (int k = 0; k < NUM_LANES; k++) word_buf[k] <= '0;
        end else begin
            hist     <= sr_next[DATA_WIDTH-2:0];
            bit_cnt  <= boundary ? '0 : bit_cnt + BW'(1);
            strobe_q <= 1'b0;
            if (state == SEARCH) begin
                if (match) begin
                    bit_cnt <= '0;
                    com_cnt <= com_upd;
                    if (acquire) begin
                        lane    <= '0;
                        los_cnt <= '0;
                    end
                end else if (boundary) begin
                    com_cnt <= '0;
                end
            end else if (los_hit) begin
                // Lost alignment: drop the partial round but keep the last delivered data.
                com_cnt <= '0;
                los_cnt <= '0;
                lane    <= '0;
                valid_q <= '0;
                idle_q  <= 1'b1;
            end else begin
                if (match) los_cnt <= boundary ? '0 : los_inc;
                if (boundary) begin
                    word_buf[lane] <= sr_next;
                    vbuf[lane]     <= !match;
                    lane           <= last_lane ? '0 : lane + LW'(1);
                    if (last_lane) begin
                        data_q   <= round_data;
                        valid_q  <= round_valid;
                        strobe_q <= 1'b1;
                        idle_q   <= (round_valid == '0);
                    end
                end
            end
        end
    end

    assign bus.data_out   = data_q;
    assign bus.valid_out  = valid_q;
    assign bus.out_strobe = strobe_q;
    assign bus.idle_out   = idle_q;
    assign bus.sync_ok    = (state == SYNCED);
endmodule

// File: tb/tb_phy_rx_param.sv
// Directed bench for phy_rx_param at default parameters (8-bit symbols, 4 lanes, COM = BC).
// Each step drives serial bits MSB first and compares outputs against hand-computed values.
module tb_phy_rx_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    phy_rx_param_if #(.DATA_WIDTH(8), .NUM_LANES(4)) bus ();

    phy_rx_param #(
        .DATA_WIDTH(8), .NUM_LANES(4), .COM(8'hBC), .SYNC_COUNT(4), .LOS_COUNT(4)
    ) dut (
        .clk_32f(clk),
        .rst    (rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.serial_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_words(input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2, input logic [7:0] w3);
        send_bits({8'h00, w0}, 8);
        send_bits({8'h00, w1}, 8);
        send_bits({8'h00, w2}, 8);
        send_bits({8'h00, w3}, 8);
    endtask

    initial begin
        bus.serial_in = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data",   bus.data_out,   32'h0);
        check("rst_valid",  {28'h0, bus.valid_out}, 32'h0);
        check("rst_strobe", {31'h0, bus.out_strobe}, 32'h0);
        check("rst_idle",   {31'h0, bus.idle_out},   32'h1);
        check("rst_sync",   {31'h0, bus.sync_ok},    32'h0);
        rst = 1'b0;

        // three stray bits, then a comma run broken by a non-comma word
        send_bits(16'h0002, 3);
        send_bits(16'h00BC, 8);
        send_bits(16'h00BC, 8);
        send_bits(16'h00BC, 8);
        send_bits(16'h0000, 8);
        check("broken_run_sync", {31'h0, bus.sync_ok}, 32'h0);

        send_bits(16'h00BC, 8);
        send_bits(16'h00BC, 8);
        send_bits(16'h00BC, 8);
        send_bits(16'h005E, 7);
        check("sync_bit31", {31'h0, bus.sync_ok}, 32'h0);
        send_bit(1'b0);
        check("sync_bit32", {31'h0, bus.sync_ok}, 32'h1);

        // round 01,02,03,04
        send_bits(16'h0001, 8);
        send_bits(16'h0002, 8);
        send_bits(16'h0003, 8);
        check("r1_strobe_pre", {31'h0, bus.out_strobe}, 32'h0);
        send_bits(16'h0004, 8);
        check("r1_strobe", {31'h0, bus.out_strobe}, 32'h1);
        check("r1_data",   bus.data_out, 32'h04030201);
        check("r1_valid",  {28'h0, bus.valid_out}, 32'hF);
        check("r1_idle",   {31'h0, bus.idle_out},  32'h0);

        // round 05,BC,07,BC; strobe must drop one cycle later while data holds
        send_bit(1'b0);
        check("r1_strobe_post", {31'h0, bus.out_strobe}, 32'h0);
        check("r1_data_hold",   bus.data_out, 32'h04030201);
        send_bits(16'h0005, 7);
        send_bits(16'h00BC, 8);
        send_bits(16'h0007, 8);
        send_bits(16'h00BC, 8);
        check("r2_strobe", {31'h0, bus.out_strobe}, 32'h1);
        check("r2_data",   bus.data_out, 32'hBC07BC05);
        check("r2_valid",  {28'h0, bus.valid_out}, 32'h5);
        check("r2_idle",   {31'h0, bus.idle_out},  32'h0);

        // all-comma round
        send_words(8'hBC, 8'hBC, 8'hBC, 8'hBC);
        check("r3_data",  bus.data_out, 32'hBCBCBCBC);
        check("r3_valid", {28'h0, bus.valid_out}, 32'h0);
        check("r3_idle",  {31'h0, bus.idle_out},  32'h1);

        // one slip bit: the shifted round (all 5E) completes just before loss of sync
        send_bit(1'b0);
        send_bits(16'h00BC, 8);
        send_bits(16'h00BC, 8);
        send_bits(16'h00BC, 8);
        check("slip_sync_held", {31'h0, bus.sync_ok}, 32'h1);
        send_bits(16'h00BC, 8);
        check("los_sync",  {31'h0, bus.sync_ok},   32'h0);
        check("los_valid", {28'h0, bus.valid_out}, 32'h0);
        check("los_idle",  {31'h0, bus.idle_out},  32'h1);
        check("los_data",  bus.data_out, 32'h5E5E5E5E);

        // re-acquire on the new phase
        send_bits(16'h00BC, 8);
        send_bits(16'h00BC, 8);
        send_bits(16'h00BC, 8);
        check("reacq_pre", {31'h0, bus.sync_ok}, 32'h0);
        send_bits(16'h00BC, 8);
        check("reacq_sync", {31'h0, bus.sync_ok}, 32'h1);
        send_words(8'h11, 8'h22, 8'h33, 8'h44);
        check("r4_data",  bus.data_out, 32'h44332211);
        check("r4_valid", {28'h0, bus.valid_out}, 32'hF);

        // reset in the middle of a round
        send_bits(16'h0055, 8);
        send_bits(16'h0066, 8);
        rst = 1'b1;
        send_bit(1'b0);
        rst = 1'b0;
        check("mid_rst_data",   bus.data_out, 32'h0);
        check("mid_rst_valid",  {28'h0, bus.valid_out},  32'h0);
        check("mid_rst_strobe", {31'h0, bus.out_strobe}, 32'h0);
        check("mid_rst_idle",   {31'h0, bus.idle_out},   32'h1);
        check("mid_rst_sync",   {31'h0, bus.sync_ok},    32'h0);

        send_words(8'hBC, 8'hBC, 8'hBC, 8'hBC);
        check("post_rst_sync", {31'h0, bus.sync_ok}, 32'h1);
        send_words(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        check("r5_data",   bus.data_out, 32'hDDCCBBAA);
        check("r5_strobe", {31'h0, bus.out_strobe}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
